// File: rtl/node_map_pkg.sv
// Shared types and constants for the node index/string mapping blocks,
// plus the packed-letter to ASCII conversion.
package node_map_pkg;

  localparam int         NODE_STR_WIDTH = 15;
  localparam int         DEF_MAX_NODES  = 1024;
  localparam int         DEF_IDX_WIDTH  = $clog2(DEF_MAX_NODES);
  localparam logic [7:0] A_CHAR         = 8'h61;

  typedef logic [NODE_STR_WIDTH-1:0] node_str_t;
  typedef logic [DEF_IDX_WIDTH-1:0]  node_idx_t;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } demap_state_t;

  // Each 5-bit field is a letter offset from 'a'; char0 lands in the top byte.
  function automatic logic [23:0] node_str_to_ascii(input node_str_t s);
    logic [7:0] c0;
    logic [7:0] c1;
    logic [7:0] c2;
    c0 = {3'b000, s[4:0]}   + A_CHAR;
    c1 = {3'b000, s[9:5]}   + A_CHAR;
    c2 = {3'b000, s[14:10]} + A_CHAR;
    return {c0, c1, c2};
  endfunction

endpackage

// File: rtl/node_str_ram.sv
// Simple dual-port storage for {bound flag, packed string}: one write port,
// one registered read port (read-first on a same-address collision), no reset.
module node_str_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_dat,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_dat
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
    if (rd_en) begin
      rd_dat <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/node_idx_demapper.sv
// Resolves a node index to its learned 3-letter string; response two edges after
// acceptance, held until resp_ready. NODE_ASCII_OUT_EN adds the registered ASCII output.
module node_idx_demapper
  import node_map_pkg::*;
#(
  parameter int NODE_STR_WIDTH = 15,
  parameter int MAX_NODES      = 1024,
  parameter int NODE_IDX_WIDTH = $clog2(MAX_NODES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      assign_valid,
  input  logic [NODE_IDX_WIDTH-1:0] assign_idx,
  input  logic [NODE_STR_WIDTH-1:0] assign_str,
  input  logic                      query_valid,
  output logic                      query_ready,
  input  logic [NODE_IDX_WIDTH-1:0] query_idx,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic                      resp_hit,
  output logic [NODE_STR_WIDTH-1:0] resp_str,
  output logic [23:0]               resp_ascii,
  output logic                      init_done
);

  localparam int RAM_W = NODE_STR_WIDTH + 1;

  demap_state_t              state;
  demap_state_t              state_nxt;
  logic [NODE_IDX_WIDTH-1:0] sweep_cnt;
  logic                      sweep_last;
  logic [NODE_IDX_WIDTH-1:0] q_idx;
  logic                      byp_vld;
  logic [NODE_STR_WIDTH-1:0] byp_str;

  logic                      wr_en;
  logic [NODE_IDX_WIDTH-1:0] wr_addr;
  logic [RAM_W-1:0]          wr_dat;
  logic                      rd_en;
  logic [NODE_IDX_WIDTH-1:0] rd_addr;
  logic [RAM_W-1:0]          rd_dat;

  logic                      hit_c;
  logic [NODE_STR_WIDTH-1:0] str_c;
  logic                      accept;

  assign sweep_last = (sweep_cnt == NODE_IDX_WIDTH'(MAX_NODES - 1));
  assign accept     = (state == IDLE) && query_valid;

  node_str_ram #(
    .DEPTH (MAX_NODES),
    .AW    (NODE_IDX_WIDTH),
    .DW    (RAM_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_dat  (wr_dat),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_dat  (rd_dat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  // The sweep owns the write port in CLEAR, so bindings offered then are dropped.
  always_comb begin
    state_nxt   = state;
    query_ready = 1'b0;
    resp_valid  = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = assign_idx;
    wr_dat      = {1'b1, assign_str};
    rd_en       = 1'b0;
    rd_addr     = query_idx;
    case (state)
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = sweep_cnt;
        wr_dat  = '0;
        if (sweep_last) begin
          state_nxt = IDLE;
        end
      end
      IDLE: begin
        query_ready = 1'b1;
        wr_en       = assign_valid;
        rd_en       = query_valid;
        if (query_valid) begin
          state_nxt = READ;
        end
      end
      READ: begin
        wr_en     = assign_valid;
        state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        wr_en      = assign_valid;
        if (resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = CLEAR;
      end
    endcase
  end

  // Newest binding wins: READ-cycle assign, then acceptance-cycle assign, then RAM.
  always_comb begin
    hit_c = rd_dat[NODE_STR_WIDTH];
    str_c = rd_dat[NODE_STR_WIDTH] ? rd_dat[NODE_STR_WIDTH-1:0] : '0;
    if (assign_valid && (assign_idx == q_idx)) begin
      hit_c = 1'b1;
      str_c = assign_str;
    end else if (byp_vld) begin
      hit_c = 1'b1;
      str_c = byp_str;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sweep_cnt <= '0;
      init_done <= 1'b0;
      q_idx     <= '0;
      byp_vld   <= 1'b0;
      byp_str   <= '0;
      resp_hit  <= 1'b0;
      resp_str  <= '0;
    end else begin
      if (state == CLEAR) begin
        sweep_cnt <= sweep_cnt + 1'b1;
        if (sweep_last) begin
          init_done <= 1'b1;
        end
      end
      if (accept) begin
        q_idx   <= query_idx;
        byp_vld <= assign_valid && (assign_idx == query_idx);
        byp_str <= assign_str;
      end
      if (state == READ) begin
        resp_hit <= hit_c;
        resp_str <= str_c;
      end
    end
  end

`ifdef NODE_ASCII_OUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_ascii <= '0;
    end else if (state == READ) begin
      resp_ascii <= hit_c ? node_str_to_ascii(str_c) : 24'h0;
    end
  end
`else
  assign resp_ascii = 24'h0;
`endif

endmodule

// File: tb/tb_node_idx_demapper.sv
// Self-checking bench for node_idx_demapper: vector table plus hand sequences
// for backpressure, throughput and reset during a pending response.
module tb_node_idx_demapper;

  localparam int MAXN = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        assign_valid;
  logic [9:0]  assign_idx;
  logic [14:0] assign_str;
  logic        query_valid;
  logic        query_ready;
  logic [9:0]  query_idx;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_hit;
  logic [14:0] resp_str;
  logic [23:0] resp_ascii;
  logic        init_done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        hit;
    logic [14:0] str;
    logic [23:0] ascii;
  } exp_t;

  typedef struct {
    logic        pre;
    logic [9:0]  pre_idx;
    logic [14:0] pre_str;
    logic [9:0]  q;
    int          mode;
    logic [9:0]  m_idx;
    logic [14:0] m_str;
    logic        hit;
    logic [14:0] str;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[12];

  node_idx_demapper dut (
    .clk          (clk),
    .rst          (rst),
    .assign_valid (assign_valid),
    .assign_idx   (assign_idx),
    .assign_str   (assign_str),
    .query_valid  (query_valid),
    .query_ready  (query_ready),
    .query_idx    (query_idx),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_hit     (resp_hit),
    .resp_str     (resp_str),
    .resp_ascii   (resp_ascii),
    .init_done    (init_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] exp_ascii(input logic hit, input logic [14:0] s);
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
`ifdef NODE_ASCII_OUT_EN
    if (!hit) return 24'h0;
    b0 = 8'h61 + {3'b000, s[4:0]};
    b1 = 8'h61 + {3'b000, s[9:5]};
    b2 = 8'h61 + {3'b000, s[14:10]};
    return {b0, b1, b2};
`else
    b0 = {3'b000, s[4:0]};
    b1 = {3'b000, s[9:5]};
    b2 = {3'b000, s[14:10]};
    return (hit && 1'b0) ? {b0, b1, b2} : 24'h0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    int n;
    bit qr_seen;
    rst          = 1'b1;
    assign_valid = 1'b0;
    query_valid  = 1'b0;
    resp_ready   = 1'b1;
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_query_ready", 32'(query_ready), 0);
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_resp_hit", 32'(resp_hit), 0);
    chk("rst_resp_str", 32'(resp_str), 0);
    chk("rst_resp_ascii", 32'(resp_ascii), 0);
    tick();
    tick();
    rst     = 1'b0;
    n       = 0;
    qr_seen = 1'b0;
    while (!init_done && n < MAXN + 20) begin
      if (query_ready) qr_seen = 1'b1;
      // a binding offered mid-sweep must be dropped
      assign_valid = (n == 100);
      assign_idx   = 10'h003;
      assign_str   = 15'h1111;
      tick();
      n++;
    end
    assign_valid = 1'b0;
    chk("sweep_cycles", 32'(n), 32'(MAXN));
    chk("sweep_query_ready_low", 32'(qr_seen), 0);
    chk("ready_after_sweep", 32'(query_ready), 1);
  endtask

  // mode 0: plain; mode 1: assign in acceptance cycle; mode 2: assign in READ cycle
  task automatic query_txn(input string nm, input logic [9:0] q, input int mode,
                           input logic [9:0] m_idx, input logic [14:0] m_str,
                           input logic hit, input logic [14:0] s);
    exp_t e;
    exp_t got;
    int lat;
    e.hit   = hit;
    e.str   = hit ? s : 15'h0;
    e.ascii = exp_ascii(hit, s);
    sb.push_back(e);
    chk({nm, "_qready"}, 32'(query_ready), 1);
    query_valid = 1'b1;
    query_idx   = q;
    if (mode == 1) begin
      assign_valid = 1'b1;
      assign_idx   = m_idx;
      assign_str   = m_str;
    end
    tick();
    lat          = 1;
    query_valid  = 1'b0;
    assign_valid = 1'b0;
    if (mode == 2) begin
      assign_valid = 1'b1;
      assign_idx   = m_idx;
      assign_str   = m_str;
    end
    while (!resp_valid && lat < 10) begin
      tick();
      lat++;
      assign_valid = 1'b0;
    end
    chk({nm, "_latency"}, 32'(lat), 2);
    if (resp_valid && sb.size() > 0) begin
      got = sb.pop_front();
      chk({nm, "_hit"}, 32'(resp_hit), 32'(got.hit));
      chk({nm, "_str"}, 32'(resp_str), 32'(got.str));
      chk({nm, "_ascii"}, 32'(resp_ascii), 32'(got.ascii));
    end else begin
      failures++;
      $display("FAIL %s_resp: no response within bound (queue depth %0d)", nm, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int acc;
    int rv;
    rst          = 1'b1;
    assign_valid = 1'b0;
    assign_idx   = '0;
    assign_str   = '0;
    query_valid  = 1'b0;
    query_idx    = '0;
    resp_ready   = 1'b1;

    vecs[0]  = '{1'b1, 10'h145, 15'h51D8, 10'h145, 0, 10'h000, 15'h0000, 1'b1, 15'h51D8};
    vecs[1]  = '{1'b0, 10'h000, 15'h0000, 10'h0a9, 0, 10'h000, 15'h0000, 1'b0, 15'h0000};
    vecs[2]  = '{1'b0, 10'h000, 15'h0000, 10'h0a9, 2, 10'h0a9, 15'h4E8E, 1'b1, 15'h4E8E};
    vecs[3]  = '{1'b0, 10'h000, 15'h0000, 10'h0a9, 0, 10'h000, 15'h0000, 1'b1, 15'h4E8E};
    vecs[4]  = '{1'b0, 10'h000, 15'h0000, 10'h003, 0, 10'h000, 15'h0000, 1'b0, 15'h0000};
    vecs[5]  = '{1'b1, 10'h145, 15'h1234, 10'h145, 0, 10'h000, 15'h0000, 1'b1, 15'h1234};
    vecs[6]  = '{1'b0, 10'h000, 15'h0000, 10'h200, 1, 10'h200, 15'h7FFF, 1'b1, 15'h7FFF};
    vecs[7]  = '{1'b0, 10'h000, 15'h0000, 10'h200, 0, 10'h000, 15'h0000, 1'b1, 15'h7FFF};
    vecs[8]  = '{1'b0, 10'h000, 15'h0000, 10'h202, 1, 10'h201, 15'h2222, 1'b0, 15'h0000};
    vecs[9]  = '{1'b0, 10'h000, 15'h0000, 10'h000, 2, 10'h3FF, 15'h0001, 1'b0, 15'h0000};
    vecs[10] = '{1'b0, 10'h000, 15'h0000, 10'h3FF, 0, 10'h000, 15'h0000, 1'b1, 15'h0001};
    vecs[11] = '{1'b1, 10'h000, 15'h0000, 10'h000, 0, 10'h000, 15'h0000, 1'b1, 15'h0000};

    do_reset();

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].pre) begin
        assign_valid = 1'b1;
        assign_idx   = vecs[i].pre_idx;
        assign_str   = vecs[i].pre_str;
        tick();
        assign_valid = 1'b0;
      end
      query_txn($sformatf("vec%0d", i), vecs[i].q, vecs[i].mode, vecs[i].m_idx,
                vecs[i].m_str, vecs[i].hit, vecs[i].str);
      tick();
    end

    // Backpressure: response must hold while a rebinding and a new query are offered
    resp_ready = 1'b0;
    query_txn("bp", 10'h145, 0, 10'h000, 15'h0000, 1'b1, 15'h1234);
    for (int i = 0; i < 5; i++) begin
      query_valid  = 1'b1;
      query_idx    = 10'h0a9;
      assign_valid = 1'b1;
      assign_idx   = 10'h145;
      assign_str   = 15'h51D8;
      tick();
      chk($sformatf("bp_hold%0d_valid", i), 32'(resp_valid), 1);
      chk($sformatf("bp_hold%0d_hit", i), 32'(resp_hit), 1);
      chk($sformatf("bp_hold%0d_str", i), 32'(resp_str), 32'h1234);
      chk($sformatf("bp_hold%0d_ascii", i), 32'(resp_ascii), 32'(exp_ascii(1'b1, 15'h1234)));
      chk($sformatf("bp_hold%0d_qready", i), 32'(query_ready), 0);
    end
    query_valid  = 1'b0;
    assign_valid = 1'b0;
    resp_ready   = 1'b1;
    tick();
    chk("bp_release_valid", 32'(resp_valid), 0);
    chk("bp_release_qready", 32'(query_ready), 1);

    // Back-to-back queries with resp_ready high: one accept every third cycle
    acc = 0;
    rv  = 0;
    query_valid = 1'b1;
    query_idx   = 10'h145;
    for (int i = 0; i < 9; i++) begin
      if (query_ready) acc++;
      if (resp_valid) rv++;
      tick();
    end
    query_valid = 1'b0;
    chk("tput_accepts", 32'(acc), 3);
    chk("tput_responses", 32'(rv), 3);
    chk("tput_idle_after", 32'(query_ready), 1);

    // Reset while a response is pending
    resp_ready = 1'b0;
    query_txn("pre_rst", 10'h145, 0, 10'h000, 15'h0000, 1'b1, 15'h51D8);
    rst = 1'b1;
    #1;
    chk("rst_in_resp_valid", 32'(resp_valid), 0);
    chk("rst_in_resp_hit", 32'(resp_hit), 0);
    chk("rst_in_resp_str", 32'(resp_str), 0);
    chk("rst_in_resp_init_done", 32'(init_done), 0);
    do_reset();
    query_txn("post_rst_145", 10'h145, 0, 10'h000, 15'h0000, 1'b0, 15'h0000);
    tick();
    query_txn("post_rst_0a9", 10'h0a9, 0, 10'h000, 15'h0000, 1'b0, 15'h0000);
    tick();
    chk("sb_empty", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
